// File: rtl/frame_uart_sender.sv
// rtl/frame_uart_sender.sv - streams a packed edge-map frame buffer to uart_tx
// with an optional leading sync header byte.
module frame_uart_sender #(
  parameter int         DEPTH       = 5100,
  parameter int         ADDR_W      = $clog2(5100),
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [7:0]        rData,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              frame_drop
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_START,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;
  logic   hdr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      hdr        <= 1'b0;
      rAddr      <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      done       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      done       <= 1'b0;
      // Frames are never queued: any tick outside idle is reported and dropped.
      frame_drop <= frame_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            rAddr <= '0;
            if (HEADER_EN) begin
              tx_data <= HEADER_BYTE;
              hdr     <= 1'b1;
              state   <= ST_START;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ:  state <= ST_LATCH;
        ST_LATCH: begin
          tx_data <= rData;
          state   <= ST_START;
        end
        ST_START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD:  state <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            if (hdr) begin
              hdr   <= 1'b0;
              state <= ST_READ;
            end else if (rAddr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              rAddr <= rAddr + 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          rAddr <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_uart_sender.sv
// tb/tb_frame_uart_sender.sv - scoreboard bench for frame_uart_sender, small
// header-enabled instance plus a full-size headerless instance.
module tb_frame_uart_sender;

  logic clk;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Instance A: DEPTH=4, header enabled
  logic       a_rst = 1'b1, a_tick = 1'b0, a_force = 1'b0;
  logic [1:0] a_raddr;
  logic [7:0] a_rdata, a_txd, a_cur;
  logic       a_txs, a_txb, a_busy, a_done, a_drop;
  logic       a_prev_txs = 1'b0, a_after_done = 1'b0;
  int         a_cnt, a_n = 10;
  int         a_starts = 0, a_dones = 0, a_drops = 0;
  logic [7:0] mem_a [4];
  logic [7:0] exp_a [$];

  frame_uart_sender #(.DEPTH(4), .ADDR_W(2), .HEADER_EN(1'b1), .HEADER_BYTE(8'hAA)) dut_a (
    .clk(clk), .reset(a_rst), .frame_tick(a_tick), .rAddr(a_raddr), .rData(a_rdata),
    .tx_data(a_txd), .tx_start(a_txs), .tx_busy(a_txb), .busy(a_busy), .done(a_done),
    .frame_drop(a_drop)
  );

  always @(posedge clk) a_rdata <= mem_a[a_raddr];

  always @(posedge clk or posedge a_rst)
    if (a_rst) a_cnt <= 0;
    else if (a_txs) a_cnt <= a_n;
    else if (a_cnt != 0) a_cnt <= a_cnt - 1;
  assign a_txb = (a_cnt != 0) || a_force;

  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_txs) begin
        a_starts++;
        chk("a_start_width", a_prev_txs, 0);
        chk("a_start_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) chk("a_byte", a_txd, exp_a.pop_front());
        a_cur = a_txd;
      end else if (a_cnt != 0) begin
        chk("a_data_stable", a_txd, a_cur);
      end
      if (a_after_done) begin
        chk("a_busy_after_done", a_busy, 0);
        chk("a_raddr_after_done", a_raddr, 0);
      end
      a_after_done = a_done;
      if (a_done) begin
        a_dones++;
        chk("a_done_all_sent", exp_a.size(), 0);
      end
      if (a_drop) a_drops++;
      a_prev_txs = a_txs;
    end
  end

  task automatic a_pulse(input bit accepted);
    if (accepted) begin
      exp_a.push_back(8'hAA);
      for (int i = 0; i < 4; i++) exp_a.push_back(mem_a[i]);
    end
    @(negedge clk) a_tick = 1'b1;
    @(negedge clk) a_tick = 1'b0;
  endtask

  task automatic a_wait_idle();
    int n = 0;
    while (a_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", n < 3000, 1);
    @(negedge clk);
  endtask

  task automatic a_check_zero(input string tag);
    chk({tag, "_raddr"}, a_raddr, 0);
    chk({tag, "_txd"}, a_txd, 0);
    chk({tag, "_txs"}, a_txs, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_drop"}, a_drop, 0);
    chk({tag, "_busy"}, a_busy, 0);
  endtask

  // Instance B: DEPTH=5100, no header, RAM data = addr[7:0]
  logic        b_rst = 1'b1, b_tick = 1'b0;
  logic [12:0] b_raddr, b_last_addr;
  logic [7:0]  b_rdata, b_txd, b_last_byte;
  logic        b_txs, b_txb, b_busy, b_done, b_drop;
  int          b_cnt, b_n;
  int          b_starts = 0, b_dones = 0, b_over = 0, b_drops = 0;
  logic [7:0]  exp_b [$];

  frame_uart_sender #(.DEPTH(5100), .ADDR_W(13), .HEADER_EN(1'b0), .HEADER_BYTE(8'hAA)) dut_b (
    .clk(clk), .reset(b_rst), .frame_tick(b_tick), .rAddr(b_raddr), .rData(b_rdata),
    .tx_data(b_txd), .tx_start(b_txs), .tx_busy(b_txb), .busy(b_busy), .done(b_done),
    .frame_drop(b_drop)
  );

  always @(posedge clk) b_rdata <= b_raddr[7:0];

  always @(posedge clk or posedge b_rst)
    if (b_rst) b_cnt <= 0;
    else if (b_txs) b_cnt <= b_n;
    else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  assign b_txb = (b_cnt != 0);

  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_raddr > 13'd5099) b_over++;
      if (b_txs) begin
        b_starts++;
        b_last_addr = b_raddr;
        b_last_byte = b_txd;
        chk("b_start_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) chk("b_byte", b_txd, exp_b.pop_front());
      end
      if (b_done) b_dones++;
      if (b_drop) b_drops++;
    end
  end

  initial begin
    int s, d, p, n;
    logic stable;
    b_n = $urandom_range(1, 3);
    repeat (3) @(negedge clk);
    a_check_zero("a_reset");
    chk("b_reset_raddr", b_raddr, 0);
    chk("b_reset_busy", b_busy, 0);
    @(negedge clk) a_rst = 1'b0;

    // single frame with the fixed test pattern
    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33; mem_a[3] = 8'h44;
    s = a_starts; d = a_dones; p = a_drops;
    a_pulse(1'b1);
    @(negedge clk);
    chk("a_hdr_latency", a_txs, 1);
    a_wait_idle();
    chk("a_single_starts", a_starts - s, 5);
    chk("a_single_dones", a_dones - d, 1);
    chk("a_single_drops", a_drops - p, 0);
    chk("a_single_raddr", a_raddr, 0);

    // second tick three cycles after the first is dropped
    s = a_starts; d = a_dones; p = a_drops;
    a_pulse(1'b1);
    repeat (2) @(negedge clk);
    a_tick = 1'b1;
    @(negedge clk) a_tick = 1'b0;
    a_wait_idle();
    chk("a_dbl_starts", a_starts - s, 5);
    chk("a_dbl_dones", a_dones - d, 1);
    chk("a_dbl_drops", a_drops - p, 1);

    // hold tx_busy high 500 cycles with the third byte waiting to go
    s = a_starts;
    a_pulse(1'b1);
    n = 0;
    while (!(a_txd == 8'h22 && !a_txs) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_stall_reach", n < 200, 1);
    a_force = 1'b1;
    d = a_starts;
    stable = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (a_txd !== 8'h22) stable = 1'b0;
    end
    chk("a_stall_no_start", a_starts - d, 0);
    chk("a_stall_data_stable", stable, 1);
    a_force = 1'b0;
    a_wait_idle();
    chk("a_stall_starts", a_starts - s, 5);

    // async reset while waiting on the second byte
    a_pulse(1'b1);
    n = 0;
    while (!(a_txs && a_txd == 8'h11) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_rst_reach", n < 200, 1);
    repeat (2) @(negedge clk);
    #1 a_rst = 1'b1;
    exp_a.delete();
    #1 a_check_zero("a_midrst");
    repeat (3) @(negedge clk);
    s = a_starts;
    chk("a_no_start_in_reset", a_txs, 0);
    a_rst = 1'b0;
    a_pulse(1'b1);
    a_wait_idle();
    chk("a_post_rst_starts", a_starts - s, 5);

    // tick coincident with done is dropped, next tick sends normally
    s = a_starts; p = a_drops;
    a_pulse(1'b1);
    n = 0;
    while (!a_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_reach", n < 300, 1);
    a_tick = 1'b1;
    @(negedge clk) a_tick = 1'b0;
    a_wait_idle();
    chk("a_done_tick_drops", a_drops - p, 1);
    chk("a_done_tick_starts", a_starts - s, 5);
    s = a_starts;
    a_pulse(1'b1);
    a_wait_idle();
    chk("a_after_drop_starts", a_starts - s, 5);

    // random contents and UART speeds
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
      a_n = $urandom_range(1, 12);
      s = a_starts;
      a_pulse(1'b1);
      a_wait_idle();
      chk("a_rand_starts", a_starts - s, 5);
    end

    // full-size headerless frame
    @(negedge clk) b_rst = 1'b0;
    for (int i = 0; i < 5100; i++) exp_b.push_back(8'(i % 256));
    @(negedge clk) b_tick = 1'b1;
    @(negedge clk) b_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_nohdr_latency", b_txs, 1);
    n = 0;
    while (b_busy && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_timeout", n < 80000, 1);
    @(negedge clk);
    chk("b_starts", b_starts, 5100);
    chk("b_last_addr", b_last_addr, 5099);
    chk("b_last_byte", b_last_byte, 8'hEB);
    chk("b_dones", b_dones, 1);
    chk("b_addr_overrange", b_over, 0);
    chk("b_drops", b_drops, 0);
    chk("b_end_raddr", b_raddr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_uart_sender.md
Name: frame_uart_sender

Overview:
- Downstream consumer of the Canny bit-packing stage.
- On that stage's frame_tick, reads the packed edge-map frame buffer (DEPTH bytes, 8 pixels per byte) from address 0 to DEPTH-1.
- Streams each byte, optionally preceded by a sync header byte, to the UART transmitter using a start/busy handshake.
- Sits between the frame buffer read port and uart_tx; feeds the host-side pen-plotter path planner.

Parameters:
- DEPTH, 5100, number of packed bytes per frame.
- ADDR_W, $clog2(5100), read address width; must equal $clog2(DEPTH).
- HEADER_EN, 1, 1 sends HEADER_BYTE before byte 0 of every frame; 0 sends no header.
- HEADER_BYTE, 8'hAA, sync byte value.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse: frame buffer complete.
- rAddr  output  ADDR_W  frame buffer read address (registered).
- rData  input  8  frame buffer read data; synchronous RAM, valid the cycle after rAddr is presented.
- tx_data  output  8  byte to transmit (registered, stable from tx_start until tx_busy falls).
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_busy  input  1  UART busy; rises no later than the cycle after tx_start and stays high until the byte is sent.
- busy  output  1  high whenever the FSM is not in ST_IDLE.
- done  output  1  one-cycle pulse after the last byte completes.
- frame_drop  output  1  one-cycle pulse when a frame_tick is ignored.

Behaviour:
- Reset (async, immediate):
  - state = ST_IDLE.
  - rAddr = 0, tx_data = 0, tx_start = 0, done = 0, frame_drop = 0, busy = 0.
  - Header flag cleared.
  - Reset mid-frame abandons the frame; no further tx_start occurs.
- All outputs are registered or decoded from the state register only; glitch-free.
- States:
  - ST_IDLE: on frame_tick, rAddr <= 0. If HEADER_EN, load tx_data <= HEADER_BYTE, set hdr flag, go ST_START. Otherwise go ST_READ.
  - ST_READ: hold rAddr one cycle so the RAM samples it; go ST_LATCH.
  - ST_LATCH: tx_data <= rData; go ST_START.
  - ST_START: wait while tx_busy = 1. When tx_busy = 0, assert tx_start on the next cycle and go ST_HOLD.
  - ST_HOLD: tx_start is high for exactly this cycle; go ST_WAIT.
  - ST_WAIT: wait until tx_busy = 0, then:
    - if hdr flag: clear it, rAddr stays 0, go ST_READ;
    - else if rAddr == DEPTH-1: go ST_DONE;
    - else: rAddr <= rAddr+1, go ST_READ.
  - ST_DONE: done = 1 for one cycle, rAddr <= 0, go ST_IDLE.
- Frame_tick handling:
  - frame_tick in any state other than ST_IDLE (ST_DONE included) is ignored and frame_drop pulses on the next cycle.
  - Frames are never queued.
- Ordering and counts:
  - Bytes go out strictly in address order.
  - Exactly DEPTH data bytes per frame, plus one header byte when HEADER_EN.
  - Exactly one tx_start per byte.
- Address width:
  - rAddr never exceeds DEPTH-1.
  - The increment is only performed when rAddr < DEPTH-1, so no wrap arithmetic occurs.
- Latency:
  - frame_tick to first tx_start: 2 cycles with header; 4 cycles without header, with tx_busy low.
  - Per data byte after tx_busy falls: READ, LATCH, START, HOLD, giving 4 cycles before the next tx_start.
- tx_busy held high stalls indefinitely in ST_START/ST_WAIT with no side effects.
- tx_data is stable from the cycle before tx_start through the byte's completion.

Test Plan:
- DEPTH=4, HEADER_EN=1, RAM preloaded 11,22,33,44, UART model busy 10 cycles/byte, one frame_tick:
  - required: bytes AA,11,22,33,44 in order, 5 tx_start pulses, each 1 cycle;
  - then done pulses once, busy falls the following cycle, rAddr = 0.
- Same config, second frame_tick 3 cycles after the first: frame_drop pulses once; output sequence identical to the single-frame case; no second frame is sent.
- tx_busy forced high for 500 cycles before the third byte: no tx_start during the stall; tx_data holds 22 stable; transmission resumes with 22 after release.
- Async reset asserted while in ST_WAIT on byte 2:
  - required: all outputs are 0 within the reset cycle;
  - a new frame_tick after reset restarts at AA, 11.
- DEPTH=5100, HEADER_EN=0, RAM data = addr[7:0]:
  - required: 5100 tx_start pulses; last rAddr = 5099 and byte = 8'hEB;
  - single done pulse; no address beyond 5099 is ever driven.
- frame_tick in the same cycle that done is high: frame_drop pulses; the next frame_tick, after busy is low, sends normally.
